traffic_light_monitor: RTL and testbench

//  Passive checker/decoder on the receiving end of traffic_light's light_ns/light_ew outputs.

---
 rtl/traffic_pkg.sv | 38 +++
 rtl/traffic_phase_timer.sv | 51 +++++
 rtl/traffic_light_monitor.sv | 104 ++++++++++
 tb/tb_traffic_light_monitor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light encodings, intersection phase encoding and decode helpers for the
// traffic light monitor.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [2:0] {
    P_UNKNOWN = 3'd0,
    P_NS_G    = 3'd1,
    P_NS_Y    = 3'd2,
    P_ALL_R   = 3'd3,
    P_EW_G    = 3'd4,
    P_EW_Y    = 3'd5
  } phase_t;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic is_green(input phase_t p);
    return (p == P_NS_G) || (p == P_EW_G);
  endfunction

  // Transitions out of P_UNKNOWN are screened by the caller, not here.
  function automatic logic legal_step(input phase_t from, input phase_t to);
    case (from)
      P_NS_G:  return to == P_NS_Y;
      P_EW_G:  return to == P_EW_Y;
      P_NS_Y:  return (to == P_ALL_R) || (to == P_EW_G);
      P_EW_Y:  return (to == P_ALL_R) || (to == P_NS_G);
      P_ALL_R: return (to == P_NS_G) || (to == P_EW_G);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Green-duration timer: measures each green, latches its length on exit and flags
// greens that fall outside [cfg, cfg + EXTEND + MARGIN].
module traffic_phase_timer #(
  parameter int W_TIME = 8,
  parameter int EXTEND = 20,
  parameter int MARGIN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              green_entry,
  input  logic              green_stay,
  input  logic              green_exit,
  input  logic              check_en,
  input  logic [W_TIME-1:0] config_time,
  output logic [W_TIME+1:0] last_green_len,
  output logic              timing_fail
);

  localparam int TW = W_TIME + 2;

  logic [TW-1:0]     timer;
  logic [W_TIME-1:0] cfg_cap;
  logic              armed;
  logic [TW-1:0]     lo_bound;
  logic [TW-1:0]     hi_bound;

  assign lo_bound    = {2'b00, cfg_cap};
  assign hi_bound    = lo_bound + TW'(EXTEND + MARGIN);
  assign timing_fail = green_exit && armed && ((timer < lo_bound) || (timer > hi_bound));

  // A green that began before the monitor came out of reset is measured but never judged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer          <= '0;
      cfg_cap        <= '0;
      armed          <= 1'b0;
      last_green_len <= '0;
    end else begin
      if (green_exit)
        last_green_len <= timer;
      if (green_entry) begin
        timer   <= TW'(1);
        cfg_cap <= config_time;
        armed   <= check_en;
      end else if (green_stay && (timer != '1)) begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for a two-axis traffic light: decodes the light buses into a
// phase, tracks the phase sequence and raises sticky encoding/conflict/sequence/timing flags.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int W_TIME = 8,
  parameter int EXTEND = 20,
  parameter int MARGIN = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_err,
  input  logic [2:0]        light_ns,
  input  logic [2:0]        light_ew,
  input  logic [W_TIME-1:0] config_time,
  output logic [2:0]        phase,
  output logic [CNT_W-1:0]  phase_count,
  output logic [W_TIME+1:0] last_green_len,
  output logic              err_encoding,
  output logic              err_conflict,
  output logic              err_sequence,
  output logic              err_timing,
  output logic              err_any
);

  phase_t phase_q;
  phase_t phase_d;
  logic   enc_bad;
  logic   conflict;
  logic   changed;
  logic   seq_bad;
  logic   green_entry;
  logic   green_stay;
  logic   green_exit;
  logic   timing_fail;

  // Malformed or conflicting buses leave the phase where it was.
  always_comb begin
    phase_d  = phase_q;
    enc_bad  = !is_onehot3(light_ns) || !is_onehot3(light_ew);
    conflict = 1'b0;
    if (!enc_bad) begin
      if ((light_ns != LIGHT_RED) && (light_ew != LIGHT_RED))
        conflict = 1'b1;
      else if (light_ns == LIGHT_GRN)
        phase_d = P_NS_G;
      else if (light_ns == LIGHT_YEL)
        phase_d = P_NS_Y;
      else if (light_ew == LIGHT_GRN)
        phase_d = P_EW_G;
      else if (light_ew == LIGHT_YEL)
        phase_d = P_EW_Y;
      else
        phase_d = P_ALL_R;
    end
  end

  assign changed     = (phase_d != phase_q);
  assign seq_bad     = changed && (phase_q != P_UNKNOWN) && !legal_step(phase_q, phase_d);
  assign green_entry = changed && is_green(phase_d);
  assign green_stay  = !changed && is_green(phase_q);
  assign green_exit  = changed && is_green(phase_q);

  traffic_phase_timer #(
    .W_TIME (W_TIME),
    .EXTEND (EXTEND),
    .MARGIN (MARGIN)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .green_entry    (green_entry),
    .green_stay     (green_stay),
    .green_exit     (green_exit),
    .check_en       (phase_q != P_UNKNOWN),
    .config_time    (config_time),
    .last_green_len (last_green_len),
    .timing_fail    (timing_fail)
  );

  // Sticky flags: a new violation in the same cycle as clear_err wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q      <= P_UNKNOWN;
      phase_count  <= '0;
      err_encoding <= 1'b0;
      err_conflict <= 1'b0;
      err_sequence <= 1'b0;
      err_timing   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (changed && (phase_q != P_UNKNOWN) && (phase_count != '1))
        phase_count <= phase_count + CNT_W'(1);
      err_encoding <= (err_encoding && !clear_err) || enc_bad;
      err_conflict <= (err_conflict && !clear_err) || conflict;
      err_sequence <= (err_sequence && !clear_err) || seq_bad;
      err_timing   <= (err_timing   && !clear_err) || timing_fail;
    end
  end

  assign phase   = phase_q;
  assign err_any = err_encoding || err_conflict || err_sequence || err_timing;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: one task per scenario with hand-computed expectations.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear_err = 1'b0;
  logic [2:0] light_ns = LIGHT_RED;
  logic [2:0] light_ew = LIGHT_RED;
  logic [7:0] config_time = 8'd10;
  logic [2:0] phase;
  logic [15:0] phase_count;
  logic [9:0] last_green_len;
  logic err_encoding, err_conflict, err_sequence, err_timing, err_any;

  int total = 0;
  int bad = 0;

  traffic_light_monitor dut (
    .clk            (clk),
    .reset          (reset),
    .clear_err      (clear_err),
    .light_ns       (light_ns),
    .light_ew       (light_ew),
    .config_time    (config_time),
    .phase          (phase),
    .phase_count    (phase_count),
    .last_green_len (last_green_len),
    .err_encoding   (err_encoding),
    .err_conflict   (err_conflict),
    .err_sequence   (err_sequence),
    .err_timing     (err_timing),
    .err_any        (err_any)
  );

  always #5 clk = ~clk;

  // Hold the given lights for n rising edges, then settle 1 time unit past the last edge.
  task automatic drive(input logic [2:0] ns, input logic [2:0] ew, input int n);
    light_ns = ns;
    light_ew = ew;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    light_ns  = LIGHT_RED;
    light_ew  = LIGHT_RED;
    clear_err = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      light_ns = 3'($urandom_range(0, 7));
      light_ew = 3'($urandom_range(0, 7));
      @(posedge clk);
    end
    #1;
    total++; if (phase !== P_UNKNOWN) begin bad++; $display("FAIL t1_phase got=%0d exp=%0d", phase, P_UNKNOWN); end
    total++; if (err_any !== 1'b0 || err_timing !== 1'b0 || err_encoding !== 1'b0) begin bad++; $display("FAIL t1_err got=%0b exp=0", err_any); end
    total++; if (phase_count !== 16'd0) begin bad++; $display("FAIL t1_count got=%0d exp=0", phase_count); end
    total++; if (last_green_len !== 10'd0) begin bad++; $display("FAIL t1_len got=%0d exp=0", last_green_len); end
    do_reset();
  endtask

  task automatic test_legal_cycle();
    do_reset();
    config_time = 8'd10;
    drive(LIGHT_GRN, LIGHT_RED, 10);
    total++; if (phase !== P_NS_G || phase_count !== 16'd0) begin bad++; $display("FAIL t2_ns_g phase=%0d cnt=%0d exp=%0d/0", phase, phase_count, P_NS_G); end
    drive(LIGHT_YEL, LIGHT_RED, 3);
    total++; if (last_green_len !== 10'd10) begin bad++; $display("FAIL t2_len1 got=%0d exp=10", last_green_len); end
    total++; if (phase !== P_NS_Y || phase_count !== 16'd1) begin bad++; $display("FAIL t2_ns_y phase=%0d cnt=%0d exp=%0d/1", phase, phase_count, P_NS_Y); end
    drive(LIGHT_RED, LIGHT_RED, 2);
    total++; if (phase !== P_ALL_R || phase_count !== 16'd2) begin bad++; $display("FAIL t2_allr phase=%0d cnt=%0d exp=%0d/2", phase, phase_count, P_ALL_R); end
    drive(LIGHT_RED, LIGHT_GRN, 10);
    total++; if (phase !== P_EW_G || phase_count !== 16'd3) begin bad++; $display("FAIL t2_ew_g phase=%0d cnt=%0d exp=%0d/3", phase, phase_count, P_EW_G); end
    drive(LIGHT_RED, LIGHT_YEL, 1);
    total++; if (last_green_len !== 10'd10) begin bad++; $display("FAIL t2_len2 got=%0d exp=10", last_green_len); end
    total++; if (err_any !== 1'b0 || phase_count !== 16'd4) begin bad++; $display("FAIL t2_clean err_any=%0b cnt=%0d exp=0/4", err_any, phase_count); end
  endtask

  task automatic test_adaptive_bound();
    do_reset();
    config_time = 8'd10;
    drive(LIGHT_GRN, LIGHT_RED, 5);
    drive(LIGHT_YEL, LIGHT_RED, 1);
    drive(LIGHT_RED, LIGHT_RED, 1);
    drive(LIGHT_RED, LIGHT_GRN, 32);
    drive(LIGHT_RED, LIGHT_YEL, 1);
    total++; if (last_green_len !== 10'd32) begin bad++; $display("FAIL t3_len32 got=%0d exp=32", last_green_len); end
    total++; if (err_timing !== 1'b0) begin bad++; $display("FAIL t3_ok32 got=%0b exp=0", err_timing); end
    drive(LIGHT_RED, LIGHT_RED, 1);
    drive(LIGHT_GRN, LIGHT_RED, 33);
    drive(LIGHT_YEL, LIGHT_RED, 1);
    total++; if (last_green_len !== 10'd33) begin bad++; $display("FAIL t3_len33 got=%0d exp=33", last_green_len); end
    total++; if (err_timing !== 1'b1 || err_any !== 1'b1) begin bad++; $display("FAIL t3_long got=%0b exp=1", err_timing); end
    clear_err = 1'b1;
    drive(LIGHT_YEL, LIGHT_RED, 1);
    clear_err = 1'b0;
    total++; if (err_timing !== 1'b0) begin bad++; $display("FAIL t3_clear got=%0b exp=0", err_timing); end
    drive(LIGHT_RED, LIGHT_RED, 1);
    drive(LIGHT_RED, LIGHT_GRN, 9);
    drive(LIGHT_RED, LIGHT_YEL, 1);
    total++; if (last_green_len !== 10'd9) begin bad++; $display("FAIL t3_len9 got=%0d exp=9", last_green_len); end
    total++; if (err_timing !== 1'b1) begin bad++; $display("FAIL t3_short got=%0b exp=1", err_timing); end
  endtask

  task automatic test_conflict();
    do_reset();
    drive(LIGHT_GRN, LIGHT_RED, 3);
    drive(LIGHT_GRN, LIGHT_YEL, 1);
    total++; if (err_conflict !== 1'b1) begin bad++; $display("FAIL t4_conflict got=%0b exp=1", err_conflict); end
    total++; if (phase !== P_NS_G) begin bad++; $display("FAIL t4_hold got=%0d exp=%0d", phase, P_NS_G); end
    total++; if (err_encoding !== 1'b0) begin bad++; $display("FAIL t4_enc got=%0b exp=0", err_encoding); end
    drive(LIGHT_GRN, LIGHT_RED, 1);
    total++; if (err_sequence !== 1'b0 || err_conflict !== 1'b1) begin bad++; $display("FAIL t4_sticky seq=%0b conf=%0b exp=0/1", err_sequence, err_conflict); end
  endtask

  task automatic test_encoding_sequence();
    do_reset();
    config_time = 8'd10;
    drive(LIGHT_RED, LIGHT_RED, 1);
    drive(3'b011, LIGHT_RED, 1);
    total++; if (err_encoding !== 1'b1) begin bad++; $display("FAIL t5_enc got=%0b exp=1", err_encoding); end
    total++; if (phase !== P_ALL_R) begin bad++; $display("FAIL t5_hold got=%0d exp=%0d", phase, P_ALL_R); end
    clear_err = 1'b1;
    drive(LIGHT_RED, LIGHT_RED, 1);
    clear_err = 1'b0;
    total++; if (err_encoding !== 1'b0) begin bad++; $display("FAIL t5_enc_clr got=%0b exp=0", err_encoding); end
    drive(LIGHT_GRN, LIGHT_RED, 2);
    drive(LIGHT_RED, LIGHT_GRN, 1);
    total++; if (err_sequence !== 1'b1) begin bad++; $display("FAIL t5_seq got=%0b exp=1", err_sequence); end
    total++; if (phase !== P_EW_G || phase_count !== 16'd2) begin bad++; $display("FAIL t5_move phase=%0d cnt=%0d exp=%0d/2", phase, phase_count, P_EW_G); end
    total++; if (err_timing !== 1'b1 || last_green_len !== 10'd2) begin bad++; $display("FAIL t5_short tim=%0b len=%0d exp=1/2", err_timing, last_green_len); end
    // Same-cycle set beats clear: an encoding fault during clear_err stays flagged.
    clear_err = 1'b1;
    drive(3'b000, LIGHT_RED, 1);
    total++; if (err_encoding !== 1'b1 || err_sequence !== 1'b0) begin bad++; $display("FAIL t5_setwins enc=%0b seq=%0b exp=1/0", err_encoding, err_sequence); end
    drive(LIGHT_RED, LIGHT_GRN, 1);
    clear_err = 1'b0;
    total++; if (err_any !== 1'b0 || err_timing !== 1'b0 || err_conflict !== 1'b0) begin bad++; $display("FAIL t5_clear_all got=%0b exp=0", err_any); end
  endtask

  task automatic test_reset_mid_green();
    do_reset();
    config_time = 8'd10;
    drive(LIGHT_RED, LIGHT_RED, 1);
    drive(LIGHT_GRN, LIGHT_RED, 5);
    reset = 1'b0;
    #2;
    total++; if (phase !== P_UNKNOWN || phase_count !== 16'd0) begin bad++; $display("FAIL t6_async phase=%0d cnt=%0d exp=%0d/0", phase, phase_count, P_UNKNOWN); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(LIGHT_GRN, LIGHT_RED, 3);
    drive(LIGHT_YEL, LIGHT_RED, 1);
    total++; if (last_green_len !== 10'd3) begin bad++; $display("FAIL t6_len got=%0d exp=3", last_green_len); end
    total++; if (err_timing !== 1'b0 || phase_count !== 16'd1) begin bad++; $display("FAIL t6_nocheck tim=%0b cnt=%0d exp=0/1", err_timing, phase_count); end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_adaptive_bound();
    test_conflict();
    test_encoding_sequence();
    test_reset_mid_green();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
